// File: rtl/ram_pkg.sv
// Shared constants for the dual-port RAM slice.
// Holds the bus address width and the legal read latency bounds.
package ram_pkg;

    localparam int unsigned BusAddrWidth   = 32;
    localparam int unsigned MinReadLatency = 1;
    localparam int unsigned MaxReadLatency = 2;

endpackage

// File: rtl/ram_rsp_pipe.sv
// Per-port response delay: carries valid/err/data for ReadLatency cycles.
// Ports: clk_i, rst_ni, req_i/err_i/rdata_i in; rvalid_o/err_o/rdata_o out.
module ram_rsp_pipe #(
    parameter int unsigned DataWidth   = 32,
    parameter int unsigned ReadLatency = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_i,
    input  logic                 err_i,
    input  logic [DataWidth-1:0] rdata_i,
    output logic                 rvalid_o,
    output logic                 err_o,
    output logic [DataWidth-1:0] rdata_o
);

    logic                 s1_valid_d, s1_valid_q;
    logic                 s1_err_d,   s1_err_q;
    logic [DataWidth-1:0] s1_data_d,  s1_data_q;

    // Data is only captured alongside a valid so rdata holds between pulses.
    always_comb begin
        s1_valid_d = req_i;
        s1_err_d   = req_i & err_i;
        s1_data_d  = s1_data_q;
        if (req_i) begin
            s1_data_d = rdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid_q <= 1'b0;
            s1_err_q   <= 1'b0;
            s1_data_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_err_q   <= s1_err_d;
            s1_data_q  <= s1_data_d;
        end
    end

    if (ReadLatency == 2) begin : g_out_reg
        logic                 s2_valid_d, s2_valid_q;
        logic                 s2_err_d,   s2_err_q;
        logic [DataWidth-1:0] s2_data_d,  s2_data_q;

        always_comb begin
            s2_valid_d = s1_valid_q;
            s2_err_d   = s1_err_q;
            s2_data_d  = s2_data_q;
            if (s1_valid_q) begin
                s2_data_d = s1_data_q;
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                s2_valid_q <= 1'b0;
                s2_err_q   <= 1'b0;
                s2_data_q  <= '0;
            end else begin
                s2_valid_q <= s2_valid_d;
                s2_err_q   <= s2_err_d;
                s2_data_q  <= s2_data_d;
            end
        end

        assign rvalid_o = s2_valid_q;
        assign err_o    = s2_err_q;
        assign rdata_o  = s2_data_q;
    end else begin : g_no_out_reg
        assign rvalid_o = s1_valid_q;
        assign err_o    = s1_err_q;
        assign rdata_o  = s1_data_q;
    end

endmodule

// File: rtl/ram_2p.sv
// Dual-port byte-enabled RAM, read-first, fixed latency, no backpressure.
// Ports: clk_i, rst_ni, per-port A/B req/we/be/addr/wdata in and
// rvalid/rdata/err out. Optional macro RAM_2P_ADDR_CHECK_EN flags
// out-of-range addresses instead of aliasing them.
module ram_2p
    import ram_pkg::*;
#(
    parameter int unsigned Depth       = 128,
    parameter int unsigned DataWidth   = 32,
    parameter int unsigned ReadLatency = 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   a_req_i,
    input  logic                   a_we_i,
    input  logic [DataWidth/8-1:0] a_be_i,
    input  logic [31:0]            a_addr_i,
    input  logic [DataWidth-1:0]   a_wdata_i,
    output logic                   a_rvalid_o,
    output logic [DataWidth-1:0]   a_rdata_o,
    output logic                   a_err_o,
    input  logic                   b_req_i,
    input  logic                   b_we_i,
    input  logic [DataWidth/8-1:0] b_be_i,
    input  logic [31:0]            b_addr_i,
    input  logic [DataWidth-1:0]   b_wdata_i,
    output logic                   b_rvalid_o,
    output logic [DataWidth-1:0]   b_rdata_o,
    output logic                   b_err_o
);

    localparam int unsigned NumBytes = DataWidth / 8;
    localparam int unsigned Aw       = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned Ab       = $clog2(NumBytes);
    localparam int unsigned IdxMsb   = Aw + Ab - 1;

    if (Depth < 2 || (Depth & (Depth - 1)) != 0) begin : g_bad_depth
        $error("ram_2p: Depth must be a power of two >= 2");
    end
    if (DataWidth != 32 && DataWidth != 64) begin : g_bad_width
        $error("ram_2p: DataWidth must be 32 or 64");
    end
    if (ReadLatency < MinReadLatency ||
        ReadLatency > MaxReadLatency) begin : g_bad_lat
        $error("ram_2p: ReadLatency must be 1 or 2");
    end
    if (IdxMsb >= BusAddrWidth - 1) begin : g_bad_span
        $error("ram_2p: Depth too large for the bus address");
    end

    logic [DataWidth-1:0] mem [Depth];

    logic [Aw-1:0]        a_idx, b_idx;
    logic                 a_oor, b_oor;
    logic                 a_wr,  b_wr;
    logic [DataWidth-1:0] a_rd,  b_rd;
    logic                 unused_addr;

    assign a_idx = a_addr_i[IdxMsb:Ab];
    assign b_idx = b_addr_i[IdxMsb:Ab];

`ifdef RAM_2P_ADDR_CHECK_EN
    assign a_oor = |a_addr_i[BusAddrWidth-1:IdxMsb+1];
    assign b_oor = |b_addr_i[BusAddrWidth-1:IdxMsb+1];
    assign unused_addr = ^{a_addr_i[Ab-1:0], b_addr_i[Ab-1:0]};
`else
    // Upper bits are dropped, so addresses alias onto the array.
    assign a_oor = 1'b0;
    assign b_oor = 1'b0;
    assign unused_addr = ^{a_addr_i[Ab-1:0], b_addr_i[Ab-1:0],
                           a_addr_i[BusAddrWidth-1:IdxMsb+1],
                           b_addr_i[BusAddrWidth-1:IdxMsb+1]};
`endif

    assign a_wr = a_req_i & a_we_i & ~a_oor;
    assign b_wr = b_req_i & b_we_i & ~b_oor;

    // Sampled before the edge, so reads and write responses see
    // the pre-write contents on both ports.
    assign a_rd = a_oor ? '0 : mem[a_idx];
    assign b_rd = b_oor ? '0 : mem[b_idx];

    // Port A is applied last so it owns bytes both ports enable.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NumBytes; i++) begin
            if (b_wr && b_be_i[i]) begin
                mem[b_idx][8*i +: 8] <= b_wdata_i[8*i +: 8];
            end
            if (a_wr && a_be_i[i]) begin
                mem[a_idx][8*i +: 8] <= a_wdata_i[8*i +: 8];
            end
        end
    end

    ram_rsp_pipe #(
        .DataWidth   (DataWidth),
        .ReadLatency (ReadLatency)
    ) u_rsp_a (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .req_i    (a_req_i),
        .err_i    (a_oor),
        .rdata_i  (a_rd),
        .rvalid_o (a_rvalid_o),
        .err_o    (a_err_o),
        .rdata_o  (a_rdata_o)
    );

    ram_rsp_pipe #(
        .DataWidth   (DataWidth),
        .ReadLatency (ReadLatency)
    ) u_rsp_b (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .req_i    (b_req_i),
        .err_i    (b_oor),
        .rdata_i  (b_rd),
        .rvalid_o (b_rvalid_o),
        .err_o    (b_err_o),
        .rdata_o  (b_rdata_o)
    );

endmodule
